// File: rtl/router_rd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : router_rd_sched
// Description : Three-port round-robin read scheduler draining output FIFOs
//               packet-by-packet onto a single ready/valid link. The optional
//               stall watchdog with FIFO flush is built when
//               ROUTER_RD_SCHED_WDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module router_rd_sched #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 30
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  fifo_empty_0,
    input  logic                  fifo_empty_1,
    input  logic                  fifo_empty_2,
    input  logic [DATA_WIDTH-1:0] head_0,
    input  logic [DATA_WIDTH-1:0] head_1,
    input  logic [DATA_WIDTH-1:0] head_2,
    input  logic                  link_ready,
    output logic                  read_enb_0,
    output logic                  read_enb_1,
    output logic                  read_enb_2,
    output logic                  link_valid,
    output logic [DATA_WIDTH-1:0] link_data,
    output logic [1:0]            link_sel,
    output logic                  link_sop,
    output logic                  link_eop,
    output logic                  soft_reset_0,
    output logic                  soft_reset_1,
    output logic                  soft_reset_2
);

    localparam int c_rem_w = DATA_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_grant;
    logic [1:0]           w_grant_nxt;
    logic [1:0]           r_last_grant;
    logic [1:0]           w_last_grant_nxt;
    logic [c_rem_w-1:0]   r_remaining;
    logic [c_rem_w-1:0]   w_remaining_nxt;
    logic [3:0]           w_req;
    logic [1:0]           w_ord0;
    logic [1:0]           w_ord1;
    logic [1:0]           w_ord2;
    logic [1:0]           w_pick;
    logic                 w_empty_sel;
    logic [DATA_WIDTH-1:0] w_head_sel;
    logic                 w_active;
    logic                 w_xfer;

    // Bit 3 is a permanent non-request so "no grant" (3) can index safely.
    assign w_req = {1'b0, ~fifo_empty_2, ~fifo_empty_1, ~fifo_empty_0};

    always_comb begin
        w_ord0 = 2'd0;
        w_ord1 = 2'd1;
        w_ord2 = 2'd2;
        case (r_last_grant)
            2'd0: begin
                w_ord0 = 2'd1;
                w_ord1 = 2'd2;
                w_ord2 = 2'd0;
            end
            2'd1: begin
                w_ord0 = 2'd2;
                w_ord1 = 2'd0;
                w_ord2 = 2'd1;
            end
            default: ;
        endcase
        w_pick = 2'd3;
        if (w_req[w_ord2]) w_pick = w_ord2;
        if (w_req[w_ord1]) w_pick = w_ord1;
        if (w_req[w_ord0]) w_pick = w_ord0;
    end

    assign link_sel = (r_state == IDLE) ? 2'd3 : r_grant;

    always_comb begin
        w_empty_sel = 1'b1;
        w_head_sel  = '0;
        case (link_sel)
            2'd0: begin
                w_empty_sel = fifo_empty_0;
                w_head_sel  = head_0;
            end
            2'd1: begin
                w_empty_sel = fifo_empty_1;
                w_head_sel  = head_1;
            end
            2'd2: begin
                w_empty_sel = fifo_empty_2;
                w_head_sel  = head_2;
            end
            default: ;
        endcase
    end

    assign w_active   = (r_state == HDR) || (r_state == BODY);
    assign link_valid = w_active && !w_empty_sel;
    assign link_data  = w_head_sel;
    assign w_xfer     = link_valid && link_ready;
    assign read_enb_0 = w_xfer && (r_grant == 2'd0);
    assign read_enb_1 = w_xfer && (r_grant == 2'd1);
    assign read_enb_2 = w_xfer && (r_grant == 2'd2);
    assign link_sop   = link_valid && (r_state == HDR);
    assign link_eop   = link_valid && (r_state == BODY) && (r_remaining == c_rem_w'(1));

`ifdef ROUTER_RD_SCHED_WDOG_EN
    logic [7:0] r_wdog;
    logic [7:0] w_wdog_nxt;
    logic       w_wdog_fire;

    // Fires on the stalled cycle that brings the count to TIMEOUT.
    assign w_wdog_fire = link_valid && !link_ready && (r_wdog == 8'(TIMEOUT - 1));

    always_comb begin
        w_wdog_nxt = r_wdog;
        if (!w_active || w_xfer) begin
            w_wdog_nxt = 8'd0;
        end else if (link_valid) begin
            w_wdog_nxt = r_wdog + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wdog <= 8'd0;
        end else begin
            r_wdog <= w_wdog_nxt;
        end
    end

    assign soft_reset_0 = (r_state == FLUSH) && (r_grant == 2'd0);
    assign soft_reset_1 = (r_state == FLUSH) && (r_grant == 2'd1);
    assign soft_reset_2 = (r_state == FLUSH) && (r_grant == 2'd2);
`else
    assign soft_reset_0 = 1'b0;
    assign soft_reset_1 = 1'b0;
    assign soft_reset_2 = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_grant_nxt = r_last_grant;
        w_remaining_nxt  = r_remaining;
        case (r_state)
            IDLE: begin
                if (w_pick != 2'd3) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = HDR;
                end
            end
            HDR: begin
                if (w_xfer) begin
                    // Payload length plus the trailing parity word.
                    w_remaining_nxt = {1'b0, w_head_sel[DATA_WIDTH-1:2]} + c_rem_w'(1);
                    w_state_nxt     = BODY;
                end
`ifdef ROUTER_RD_SCHED_WDOG_EN
                else if (w_wdog_fire) begin
                    w_state_nxt = FLUSH;
                end
`endif
            end
            BODY: begin
                if (w_xfer) begin
                    w_remaining_nxt = r_remaining - c_rem_w'(1);
                    if (r_remaining == c_rem_w'(1)) begin
                        w_state_nxt      = IDLE;
                        w_last_grant_nxt = r_grant;
                    end
                end
`ifdef ROUTER_RD_SCHED_WDOG_EN
                else if (w_wdog_fire) begin
                    w_state_nxt = FLUSH;
                end
`endif
            end
            FLUSH: begin
                w_last_grant_nxt = r_grant;
                w_state_nxt      = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_grant      <= 2'd3;
            r_last_grant <= 2'd2;
            r_remaining  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_remaining  <= w_remaining_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_rd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_router_rd_sched
// Description : Randomized and directed self-checking bench for
//               router_rd_sched against a packet-level FIFO/link model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_rd_sched;

    localparam int DW  = 8;
    localparam int TMO = 30;

    logic          clock = 1'b0;
    logic          resetn;
    logic          fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic [DW-1:0] head_0, head_1, head_2;
    logic          link_ready;
    logic          read_enb_0, read_enb_1, read_enb_2;
    logic          link_valid;
    logic [DW-1:0] link_data;
    logic [1:0]    link_sel;
    logic          link_sop, link_eop;
    logic          soft_reset_0, soft_reset_1, soft_reset_2;

    always #5 clock = ~clock;

    router_rd_sched #(.DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .fifo_empty_0 (fifo_empty_0),
        .fifo_empty_1 (fifo_empty_1),
        .fifo_empty_2 (fifo_empty_2),
        .head_0       (head_0),
        .head_1       (head_1),
        .head_2       (head_2),
        .link_ready   (link_ready),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .link_valid   (link_valid),
        .link_data    (link_data),
        .link_sel     (link_sel),
        .link_sop     (link_sop),
        .link_eop     (link_eop),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO contents as seen by the bench
    logic [DW-1:0] q0[$], q1[$], q2[$];
    logic [2:0]    hide;
    logic          rdy;

    function automatic int q_size(input int p);
        case (p)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [DW-1:0] q_front(input int p);
        if (q_size(p) == 0) return '0;
        case (p)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic q_push(input int p, input logic [DW-1:0] w);
        case (p)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    task automatic q_pop(input int p);
        logic [DW-1:0] d;
        case (p)
            0:       d = q0.pop_front();
            1:       d = q1.pop_front();
            default: d = q2.pop_front();
        endcase
    endtask

    task automatic q_clear(input int p);
        case (p)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic push_pkt(input int p, input logic [DW-1:0] hdr);
        logic [DW-1:0] par;
        logic [DW-1:0] w;
        par = hdr;
        q_push(p, hdr);
        for (int i = 0; i < int'(hdr >> 2); i++) begin
            w = DW'($urandom);
            par ^= w;
            q_push(p, w);
        end
        q_push(p, par);
    endtask

    // Packet-level reference model state
    bit   m_busy, m_flush;
    int   m_port, m_idx, m_left, m_last, m_stall;
    bit [2:0] pop_f, flush_f;

    // Observed-activity counters
    int   re_cnt[3];
    int   sr_cnt[3];
    int   sop_cnt, eop_cnt, xfer_cnt;
    int   sel_log[$];
    logic [1:0] prev_sel;

    task automatic model_reset();
        m_busy = 0; m_flush = 0; m_last = 2; m_stall = 0; m_idx = 0; m_left = 0; m_port = 0;
        for (int p = 0; p < 3; p++) q_clear(p);
    endtask

    task automatic clr_counts();
        for (int p = 0; p < 3; p++) begin
            re_cnt[p] = 0;
            sr_cnt[p] = 0;
        end
        sop_cnt = 0; eop_cnt = 0; xfer_cnt = 0;
        sel_log.delete();
    endtask

    function automatic bit model_idle();
        return !m_busy && !m_flush && q_size(0) == 0 && q_size(1) == 0 && q_size(2) == 0;
    endfunction

    task automatic drive_fifos();
        fifo_empty_0 = hide[0] || q_size(0) == 0;
        fifo_empty_1 = hide[1] || q_size(1) == 0;
        fifo_empty_2 = hide[2] || q_size(2) == 0;
        head_0 = q_front(0);
        head_1 = q_front(1);
        head_2 = q_front(2);
        link_ready = rdy;
    endtask

    task automatic model_check();
        logic [1:0]    e_sel;
        logic          e_valid, e_sop, e_eop;
        logic [2:0]    e_re, e_sr;
        logic [DW-1:0] e_data;
        bit            vis[3];
        bit            xfer;
        e_sel = 2'd3; e_valid = 0; e_sop = 0; e_eop = 0; e_re = 0; e_sr = 0; e_data = 0;
        pop_f = 0; flush_f = 0; xfer = 0;
        for (int p = 0; p < 3; p++) vis[p] = !hide[p] && q_size(p) > 0;
        if (resetn) begin
            if (m_flush) begin
                e_sel = 2'(m_port);
                e_sr[m_port] = 1'b1;
                flush_f[m_port] = 1'b1;
                m_flush = 0; m_busy = 0; m_last = m_port;
            end else if (m_busy) begin
                e_sel   = 2'(m_port);
                e_valid = vis[m_port];
                e_data  = q_front(m_port);
                e_sop   = e_valid && m_idx == 0;
                e_eop   = e_valid && m_idx > 0 && m_left == 1;
                xfer    = e_valid && rdy;
                e_re[m_port] = xfer;
                if (xfer) begin
                    pop_f[m_port] = 1'b1;
                    m_stall = 0;
                    if (m_idx == 0) m_left = int'(q_front(m_port) >> 2) + 1;
                    else            m_left--;
                    m_idx++;
                    if (m_idx > 1 && m_left == 0) begin
                        m_busy = 0;
                        m_last = m_port;
                    end
                end else if (e_valid) begin
                    m_stall++;
`ifdef ROUTER_RD_SCHED_WDOG_EN
                    if (m_stall == TMO) m_flush = 1;
`endif
                end
            end else begin
                for (int i = 1; i <= 3; i++) begin
                    int p;
                    p = (m_last + i) % 3;
                    if (!m_busy && vis[p]) begin
                        m_busy = 1; m_port = p; m_idx = 0; m_stall = 0;
                    end
                end
            end
        end
        check_eq("link_sel", link_sel, e_sel);
        check_eq("link_valid", link_valid, e_valid);
        check_eq("link_sop", link_sop, e_sop);
        check_eq("link_eop", link_eop, e_eop);
        check_eq("read_enb", {read_enb_2, read_enb_1, read_enb_0}, e_re);
        check_eq("soft_reset", {soft_reset_2, soft_reset_1, soft_reset_0}, e_sr);
        if (e_valid) check_eq("link_data", link_data, e_data);
        re_cnt[0] += int'(read_enb_0);
        re_cnt[1] += int'(read_enb_1);
        re_cnt[2] += int'(read_enb_2);
        sr_cnt[0] += int'(soft_reset_0);
        sr_cnt[1] += int'(soft_reset_1);
        sr_cnt[2] += int'(soft_reset_2);
        sop_cnt   += int'(link_sop);
        eop_cnt   += int'(link_eop);
        xfer_cnt  += int'(link_valid && link_ready);
        if (prev_sel == 2'd3 && link_sel != 2'd3) sel_log.push_back(int'(link_sel));
        prev_sel = link_sel;
    endtask

    task automatic step();
        drive_fifos();
        @(negedge clock);
        model_check();
        @(posedge clock);
        #1;
        for (int p = 0; p < 3; p++) begin
            if (flush_f[p])    q_clear(p);
            else if (pop_f[p]) q_pop(p);
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        n = 0;
        while (n < max && !model_idle()) begin
            step();
            n++;
        end
        step();
        check_eq(tag, model_idle(), 1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        repeat (2) step();
        resetn = 1'b1;
    endtask

    function automatic int log_at(input int i);
        return (sel_log.size() > i) ? sel_log[i] : 3;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        resetn = 1'b0; rdy = 1'b1; hide = 3'b000; prev_sel = 2'd3;
        model_reset();
        clr_counts();
        drive_fifos();
        repeat (3) step();
        check_eq("rst_sel", link_sel, 2'd3);
        check_eq("rst_data", link_data, '0);
        resetn = 1'b1;

        // Single packet, header 0x0D on port 1
        clr_counts();
        push_pkt(1, 8'h0D);
        step();
        check_eq("pkt_grant_latency", link_sel, 2'd1);
        run_idle("pkt_drain", 50);
        check_eq("pkt_reads", re_cnt[1], 5);
        check_eq("pkt_sop", sop_cnt, 1);
        check_eq("pkt_eop", eop_cnt, 1);

        // Round-robin from reset
        do_reset();
        clr_counts();
        for (int p = 0; p < 3; p++) push_pkt(p, 8'h04);
        run_idle("rr_drain", 60);
        check_eq("rr_first", log_at(0), 0);
        check_eq("rr_second", log_at(1), 1);
        check_eq("rr_third", log_at(2), 2);
        for (int p = 0; p < 3; p++) check_eq("rr_reads", re_cnt[p], 3);

        // Zero-length packet
        clr_counts();
        push_pkt(2, 8'h02);
        run_idle("zero_drain", 30);
        check_eq("zero_xfers", xfer_cnt, 2);
        check_eq("zero_sop", sop_cnt, 1);
        check_eq("zero_eop", eop_cnt, 1);

        // Mid-packet underflow
        clr_counts();
        push_pkt(0, {6'd5, 2'b11});
        n = 0;
        while (n < 20 && xfer_cnt < 3) begin
            step();
            n++;
        end
        check_eq("uflow_reach", xfer_cnt, 3);
        hide = 3'b001;
        repeat (4) step();
        check_eq("uflow_hold_sel", link_sel, 2'd0);
        hide = 3'b000;
        run_idle("uflow_drain", 40);
        check_eq("uflow_reads", re_cnt[0], 7);

        // Stall on link_ready low
        clr_counts();
        rdy = 1'b0;
        push_pkt(0, 8'h0C);
        repeat (2) step();
        push_pkt(1, 8'h04);
        repeat (TMO + 6) step();
`ifdef ROUTER_RD_SCHED_WDOG_EN
        check_eq("wdog_pulses", sr_cnt[0], 1);
`else
        check_eq("wdog_pulses", sr_cnt[0], 0);
`endif
        check_eq("wdog_other", sr_cnt[1], 0);
        rdy = 1'b1;
        run_idle("wdog_drain", 200);
        check_eq("wdog_next_grant", log_at(1), 1);

        // Asynchronous reset mid-body
        clr_counts();
        push_pkt(1, 8'h18);
        n = 0;
        while (n < 30 && !(m_busy && m_idx >= 2)) begin
            step();
            n++;
        end
        check_eq("arst_in_body", m_busy && m_idx >= 2, 1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_sel", link_sel, 2'd3);
        check_eq("arst_valid", link_valid, 1'b0);
        check_eq("arst_re", {read_enb_2, read_enb_1, read_enb_0}, 3'b000);
        check_eq("arst_sr", {soft_reset_2, soft_reset_1, soft_reset_0}, 3'b000);
        check_eq("arst_sop_eop", {link_sop, link_eop}, 2'b00);
        check_eq("arst_data", link_data, '0);
        model_reset();
        repeat (2) step();
        resetn = 1'b1;

        // Randomized traffic
        clr_counts();
        repeat (1500) begin
            int p;
            if ($urandom_range(0, 3) == 0) begin
                p = int'($urandom_range(0, 2));
                if (q_size(p) < 20) push_pkt(p, {6'($urandom_range(0, 7)), 2'($urandom)});
            end
            rdy  = ($urandom_range(0, 3) != 0);
            hide = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b000;
            step();
        end
        rdy = 1'b1;
        hide = 3'b000;
        run_idle("rand_drain", 3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
